// File: rtl/latch_seven_seg_display.sv
// latch_seven_seg_display
// Two-digit BCD event counter (00-99) driving two registered, active-high
// seven-segment displays (Display_L = tens, Display_R = units).
// Blanking darkens both displays without affecting the count.
// Optional feature macro: LSSD_LEADING_ZERO_BLANK_EN suppresses a leading
// zero in the tens digit (Display_L dark when tens == 0 and not blanked).
module latch_seven_seg_display (
    input  logic       clock,
    input  logic       reset,
    input  logic       Blanking,
    input  logic       Enable,
    output logic [6:0] Display_L,
    output logic [6:0] Display_R
);

    localparam logic [6:0] SEG_DARK = 7'h00;
    localparam logic [6:0] SEG_ZERO = 7'h7E;

`ifdef LSSD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] RST_L = SEG_DARK;
`else
    localparam logic [6:0] RST_L = SEG_ZERO;
`endif

    logic [3:0] tens, units;
    logic [3:0] tens_nxt, units_nxt;
    logic [6:0] seg_l_nxt, seg_r_nxt;

    // BCD digit to a..g segments (bit6 = a); codes 10-15 stay dark
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h7E;
            4'd1:    seg_decode = 7'h30;
            4'd2:    seg_decode = 7'h6D;
            4'd3:    seg_decode = 7'h79;
            4'd4:    seg_decode = 7'h33;
            4'd5:    seg_decode = 7'h5B;
            4'd6:    seg_decode = 7'h5F;
            4'd7:    seg_decode = 7'h70;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h7B;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Next count: BCD increment with units->tens carry and 99->00 wrap
    always_comb begin
        tens_nxt  = tens;
        units_nxt = units;
        if (Enable) begin
            if (units == 4'd9) begin
                units_nxt = 4'd0;
                tens_nxt  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                units_nxt = units + 4'd1;
            end
        end
    end

    // Segments are decoded from the next count so displays never lag the count
    always_comb begin
        seg_r_nxt = seg_decode(units_nxt);
`ifdef LSSD_LEADING_ZERO_BLANK_EN
        seg_l_nxt = (tens_nxt == 4'd0) ? SEG_DARK : seg_decode(tens_nxt);
`else
        seg_l_nxt = seg_decode(tens_nxt);
`endif
    end

    // Count register: reset clears, otherwise load next (hold when disabled)
    always_ff @(posedge clock) begin
        if (reset) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else begin
            tens  <= tens_nxt;
            units <= units_nxt;
        end
    end

    // Display registers: reset shows "00", blanking darkens, else show count
    always_ff @(posedge clock) begin
        if (reset) begin
            Display_L <= RST_L;
            Display_R <= SEG_ZERO;
        end else if (Blanking) begin
            Display_L <= SEG_DARK;
            Display_R <= SEG_DARK;
        end else begin
            Display_L <= seg_l_nxt;
            Display_R <= seg_r_nxt;
        end
    end

endmodule

// File: tb/tb_latch_seven_seg_display.sv
// tb_latch_seven_seg_display
// Directed test of the two-digit seven-segment counter: reset, counting,
// blanking, hold, 99->00 wrap and mid-count reset. Honors the
// LSSD_LEADING_ZERO_BLANK_EN macro when computing expected tens segments.
`timescale 1us/1ns
module tb_latch_seven_seg_display;

    logic       clock = 1'b0;
    logic       reset, Blanking, Enable;
    logic [6:0] Display_L, Display_R;

    int n_asserts = 0;
    int n_fails   = 0;
    int cnt       = 0;   // expected decimal count 0..99

    latch_seven_seg_display dut (
        .clock     (clock),
        .reset     (reset),
        .Blanking  (Blanking),
        .Enable    (Enable),
        .Display_L (Display_L),
        .Display_R (Display_R)
    );

    // 10 us period, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h7E; 1: seg = 7'h30; 2: seg = 7'h6D; 3: seg = 7'h79;
            4: seg = 7'h33; 5: seg = 7'h5B; 6: seg = 7'h5F; 7: seg = 7'h70;
            8: seg = 7'h7F; 9: seg = 7'h7B; default: seg = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_tens(input int d);
`ifdef LSSD_LEADING_ZERO_BLANK_EN
        seg_tens = (d == 0) ? 7'h00 : seg(d);
`else
        seg_tens = seg(d);
`endif
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the expected count, then check both displays
    task automatic tick(input string tag);
        logic [6:0] exp_l, exp_r;
        @(posedge clock);
        if (reset)       cnt = 0;
        else if (Enable) cnt = (cnt + 1) % 100;
        if (reset) begin
            exp_l = seg_tens(0);
            exp_r = 7'h7E;
        end else if (Blanking) begin
            exp_l = 7'h00;
            exp_r = 7'h00;
        end else begin
            exp_l = seg_tens(cnt / 10);
            exp_r = seg(cnt % 10);
        end
        #2;
        check({tag, "_L"}, Display_L, exp_l);
        check({tag, "_R"}, Display_R, exp_r);
    endtask

    initial begin
        reset = 1'b1; Enable = 1'b0; Blanking = 1'b0;

        // Reset for two edges, then idle with Enable low
        tick("reset0");
        tick("reset1");
        reset = 1'b0;
        tick("idle");
        check("idle_R_const", Display_R, 7'h7E);

        // Count 1..10; units step through the decode table
        Enable = 1'b1;
        for (int i = 1; i <= 10; i++) tick("count");
        check("ten_L_const", Display_L, 7'h30);
        check("ten_R_const", Display_R, 7'h7E);

        // Advance to 17, then blank for 5 edges while counting
        for (int i = 0; i < 7; i++) tick("count2");
        Blanking = 1'b1;
        for (int i = 0; i < 5; i++) tick("blank");
        check("blank_L_const", Display_L, 7'h00);
        Blanking = 1'b0;
        tick("unblank");   // 17 + 5 blanked + 1 = 23
        check("unblank_L_const", Display_L, 7'h6D);
        check("unblank_R_const", Display_R, 7'h79);

        // Hold: outputs freeze at 23
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_R_const", Display_R, 7'h79);

        // Blank while holding, then release: same count reappears
        Blanking = 1'b1;
        tick("blank_hold");
        Blanking = 1'b0;
        tick("unblank_hold");

        // Wrap: from 00, 100 enabled edges return to 00
        reset = 1'b1;
        tick("rst_wrap");
        reset = 1'b0;
        Enable = 1'b1;
        for (int i = 1; i <= 99; i++) tick("wrap");
        check("w99_L_const", Display_L, seg_tens(9));
        check("w99_R_const", Display_R, 7'h7B);
        tick("wrap100");
        check("w00_L_const", Display_L, seg_tens(0));
        check("w00_R_const", Display_R, 7'h7E);

        // Reset mid-count at 47 with Enable and Blanking both high
        for (int i = 0; i < 47; i++) tick("to47");
        reset = 1'b1; Blanking = 1'b1;
        tick("midrst");
        check("midrst_R_const", Display_R, 7'h7E);
        reset = 1'b0; Blanking = 1'b0;
        tick("resume1");
        check("resume1_R_const", Display_R, 7'h30);
        tick("resume2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this
    initial begin
        #50000;
        n_fails++;
        $display("FAIL timeout: observed no completion expected finish before 50000 us");
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
